vram_hdma: RTL and testbench

VRAM_HDMA -- requirements
Module: vram_hdma

---
 rtl/gbc_pkg.sv | 26 ++
 rtl/hdma_byte_mover.sv | 75 +++++++
 rtl/vram_hdma.sv | 171 +++++++++++++++++
 tb/tb_vram_hdma.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbc_pkg.sv
// Shared types and constants for the CGB VRAM DMA block.
// Register indices map HDMA1..HDMA5 (FF51..FF55) onto reg_sel_i.
package gbc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GDMA_XFER,
    HB_WAIT,
    HB_XFER
  } hdma_state_t;

  typedef enum logic [1:0] {
    MV_IDLE,
    MV_REQ,
    MV_WR
  } mover_state_t;

  localparam logic [2:0] HDMA1 = 3'd0;
  localparam logic [2:0] HDMA2 = 3'd1;
  localparam logic [2:0] HDMA3 = 3'd2;
  localparam logic [2:0] HDMA4 = 3'd3;
  localparam logic [2:0] HDMA5 = 3'd4;

  localparam int HDMA_BLOCK_BYTES = 16;

endpackage

// File: rtl/hdma_byte_mover.sv
// Read-capture-write sequencer moving one byte at a time into VRAM.
// Owns the live source/destination address counters.
module hdma_byte_mover
  import gbc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [15:0] src_ld_i,
  input  logic [12:0] dst_ld_i,
  input  logic        run_i,
  input  logic        src_valid_i,
  input  logic [7:0]  src_rdata_i,
  output logic        src_req_o,
  output logic [15:0] src_addr_o,
  output logic        vram_we_o,
  output logic [12:0] vram_addr_o,
  output logic [7:0]  vram_wdata_o
);

  mover_state_t state_q, state_d;
  logic [15:0]  src_q;
  logic [12:0]  dst_q;
  logic [7:0]   data_q;

  assign src_addr_o   = src_q;
  assign vram_addr_o  = dst_q;
  assign vram_wdata_o = data_q;

  // Next-state and strobes; WR chains straight into REQ for 2 cycles/byte.
  always_comb begin
    state_d   = state_q;
    src_req_o = 1'b0;
    vram_we_o = 1'b0;
    unique case (state_q)
      MV_IDLE: begin
        if (run_i) state_d = MV_REQ;
      end
      MV_REQ: begin
        src_req_o = 1'b1;
        if (src_valid_i) state_d = MV_WR;
      end
      MV_WR: begin
        vram_we_o = 1'b1;
        state_d   = run_i ? MV_REQ : MV_IDLE;
      end
      default: state_d = MV_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= MV_IDLE;
    else         state_q <= state_d;
  end

  // Address counters advance after each write; data captured on valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q  <= '0;
      dst_q  <= '0;
      data_q <= '0;
    end else begin
      if (load_i) begin
        src_q <= src_ld_i;
        dst_q <= dst_ld_i;
      end else if (state_q == MV_WR) begin
        src_q <= src_q + 16'd1;
        dst_q <= dst_q + 13'd1;
      end
      if (state_q == MV_REQ && src_valid_i) data_q <= src_rdata_i;
    end
  end

endmodule

// File: rtl/vram_hdma.sv
// CGB VRAM DMA: HDMA1-5 register file and general/H-blank transfer FSM.
// Byte movement is delegated to hdma_byte_mover.
module vram_hdma
  import gbc_pkg::*;
#(
  parameter int BLOCK_BYTES = HDMA_BLOCK_BYTES
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [2:0]  reg_sel_i,
  input  logic        reg_wr_i,
  input  logic        reg_rd_i,
  input  logic [7:0]  reg_wdata_i,
  output logic [7:0]  reg_rdata_o,
  input  logic        hblank_start_i,
  input  logic        lcd_on_i,
  output logic        src_req_o,
  output logic [15:0] src_addr_o,
  input  logic        src_valid_i,
  input  logic [7:0]  src_rdata_i,
  output logic        vram_we_o,
  output logic [12:0] vram_addr_o,
  output logic [7:0]  vram_wdata_o,
  output logic        cpu_stall_o
);

  localparam logic [7:0] LAST = 8'(BLOCK_BYTES - 1);

  hdma_state_t state_q, state_d;
  logic [15:4] src_prog_q;
  logic [12:4] dst_prog_q;
  logic [6:0]  rem_q, rem_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        term_q, term_d;
  logic        stop_q, stop_d;
  logic        load;
  logic        run;
  logic        hdma5_wr;
  logic        stop_now;
  logic        blk_end;
  logic [7:0]  hdma5_val;

  assign hdma5_wr    = reg_wr_i && reg_sel_i == HDMA5;
  assign stop_now    = hdma5_wr && !reg_wdata_i[7];
  assign blk_end     = vram_we_o && cnt_q == LAST;
  assign cpu_stall_o = state_q == GDMA_XFER || state_q == HB_XFER;

  // Mover keeps going until the block (or whole GDMA) ends this cycle.
  assign run = (state_q == GDMA_XFER && !(blk_end && rem_q == '0))
            || (state_q == HB_XFER && !blk_end);

  hdma_byte_mover u_mover (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_i       (load),
    .src_ld_i     ({src_prog_q, 4'h0}),
    .dst_ld_i     ({dst_prog_q, 4'h0}),
    .run_i        (run),
    .src_valid_i  (src_valid_i),
    .src_rdata_i  (src_rdata_i),
    .src_req_o    (src_req_o),
    .src_addr_o   (src_addr_o),
    .vram_we_o    (vram_we_o),
    .vram_addr_o  (vram_addr_o),
    .vram_wdata_o (vram_wdata_o)
  );

  // Register read mux; reflects state before any same-cycle write.
  always_comb begin
    if (state_q == IDLE) hdma5_val = term_q ? {1'b1, rem_q} : 8'hFF;
    else                 hdma5_val = {1'b0, rem_q};
    reg_rdata_o = 8'h00;
    if (reg_rd_i) reg_rdata_o = (reg_sel_i == HDMA5) ? hdma5_val : 8'hFF;
  end

  // Transfer FSM: next state, block/byte counters and termination flags.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    term_d  = term_q;
    stop_d  = stop_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hdma5_wr) begin
          load   = 1'b1;
          rem_d  = reg_wdata_i[6:0];
          cnt_d  = '0;
          term_d = 1'b0;
          stop_d = 1'b0;
          if (!reg_wdata_i[7])  state_d = GDMA_XFER;
          else if (lcd_on_i)    state_d = HB_WAIT;
          else                  state_d = HB_XFER;
        end
      end
      GDMA_XFER: begin
        if (blk_end) begin
          cnt_d = '0;
          if (rem_q == '0) state_d = IDLE;
          else             rem_d   = rem_q - 7'd1;
        end else if (vram_we_o) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HB_WAIT: begin
        if (stop_now) begin
          state_d = IDLE;
          term_d  = 1'b1;
        end else if (hblank_start_i) begin
          state_d = HB_XFER;
        end
      end
      HB_XFER: begin
        if (stop_now) stop_d = 1'b1;
        if (blk_end) begin
          cnt_d  = '0;
          stop_d = 1'b0;
          if (rem_q == '0) begin
            state_d = IDLE;
          end else begin
            rem_d = rem_q - 7'd1;
            if (stop_q || stop_now) begin
              state_d = IDLE;
              term_d  = 1'b1;
            end else begin
              state_d = HB_WAIT;
            end
          end
        end else if (vram_we_o) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and live counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      term_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      term_q  <= term_d;
      stop_q  <= stop_d;
    end
  end

  // Programmed source/destination; never touches the live counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_prog_q <= '0;
      dst_prog_q <= '0;
    end else if (reg_wr_i) begin
      unique case (reg_sel_i)
        HDMA1:   src_prog_q[15:8] <= reg_wdata_i;
        HDMA2:   src_prog_q[7:4]  <= reg_wdata_i[7:4];
        HDMA3:   dst_prog_q[12:8] <= reg_wdata_i[4:0];
        HDMA4:   dst_prog_q[7:4]  <= reg_wdata_i[7:4];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_hdma.sv
// Directed bench for vram_hdma: GDMA, H-blank, terminate, wrap,
// reset abort and LCD-off cases against hand-computed values.
module tb_vram_hdma;
  import gbc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [2:0]  sel = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        hb = 1'b0;
  logic        lcd = 1'b1;
  logic        src_req;
  logic [15:0] src_addr;
  logic        src_valid = 1'b0;
  logic [7:0]  src_rdata = '0;
  logic        we;
  logic [12:0] vaddr;
  logic [7:0]  vdata;
  logic        stall;

  int n_run = 0;
  int n_fail = 0;
  int bad_stall = 0;
  bit seen = 1'b0;
  logic [12:0] wa[$];
  logic [7:0]  wd[$];
  logic [7:0]  v;

  vram_hdma #(.BLOCK_BYTES(16)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .reg_sel_i      (sel),
    .reg_wr_i       (wr),
    .reg_rd_i       (rd),
    .reg_wdata_i    (wdata),
    .reg_rdata_o    (rdata),
    .hblank_start_i (hb),
    .lcd_on_i       (lcd),
    .src_req_o      (src_req),
    .src_addr_o     (src_addr),
    .src_valid_i    (src_valid),
    .src_rdata_i    (src_rdata),
    .vram_we_o      (we),
    .vram_addr_o    (vaddr),
    .vram_wdata_o   (vdata),
    .cpu_stall_o    (stall)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Source memory answers one cycle after a request is seen.
  always @(posedge clk) begin
    #1;
    if (!rst_ni) begin
      src_valid = 1'b0;
      seen = 1'b0;
    end else if (src_valid) begin
      src_valid = 1'b0;
      seen = 1'b0;
    end else if (src_req) begin
      if (seen) begin
        src_valid = 1'b1;
        src_rdata = f(src_addr);
      end else begin
        seen = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_ni && we) begin
      wa.push_back(vaddr);
      wd.push_back(vdata);
      if (!stall) bad_stall++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wreg(input logic [2:0] s, input logic [7:0] d);
    @(negedge clk);
    sel = s; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic rd5(output logic [7:0] r);
    @(negedge clk);
    sel = HDMA5; rd = 1'b1;
    #1 r = rdata;
    rd = 1'b0;
  endtask

  task automatic pulse();
    @(negedge clk);
    hb = 1'b1;
    @(negedge clk);
    hb = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    chk({tag, "_timeout"}, {31'd0, done}, 32'd1);
  endtask

  task automatic prog(input logic [15:0] s, input logic [12:0] d);
    wreg(HDMA1, s[15:8]);
    wreg(HDMA2, s[7:0]);
    wreg(HDMA3, {3'b100, d[12:8]});
    wreg(HDMA4, d[7:0]);
  endtask

  task automatic chk_block(input string tag, input int base,
                           input logic [15:0] s, input logic [12:0] d);
    int ea = 0;
    int ed = 0;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] sa;
      logic [12:0] da;
      sa = s + 16'(i);
      da = d + 13'(i);
      if (wa[base+i] !== da) ea++;
      if (wd[base+i] !== f(sa)) ed++;
    end
    chk({tag, "_addr_errs"}, 32'(ea), 32'd0);
    chk({tag, "_data_errs"}, 32'(ed), 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_src_addr", {16'd0, src_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    rd5(v);
    chk("rst_hdma5", {24'd0, v}, 32'hFF);
    sel = HDMA1; rd = 1'b1;
    #1 chk("rd_hdma1", {24'd0, rdata}, 32'hFF);
    rd = 1'b0;

    // GDMA, 16 bytes from C000 to 8000
    prog(16'hC000, 13'h0000);
    wreg(HDMA5, 8'h00);
    chk("gdma_stall_on", {31'd0, stall}, 32'd1);
    wait_idle("gdma");
    chk("gdma_count", 32'(wa.size()), 32'd16);
    if (wa.size() == 16) chk_block("gdma", 0, 16'hC000, 13'h0000);
    chk("gdma_stall_during", 32'(bad_stall), 32'd0);
    rd5(v);
    chk("gdma_hdma5", {24'd0, v}, 32'hFF);

    // H-blank, two blocks; read+write same cycle returns old value
    wa.delete(); wd.delete();
    prog(16'hD000, 13'h0100);
    @(negedge clk);
    sel = HDMA5; wdata = 8'h81; wr = 1'b1; rd = 1'b1;
    #1 chk("rw_same_cycle", {24'd0, rdata}, 32'hFF);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    repeat (20) @(negedge clk);
    chk("hb_no_xfer", 32'(wa.size()), 32'd0);
    chk("hb_wait_stall", {31'd0, stall}, 32'd0);
    rd5(v);
    chk("hb_hdma5_a", {24'd0, v}, 32'h01);
    pulse();
    wait_idle("hb1");
    chk("hb1_count", 32'(wa.size()), 32'd16);
    rd5(v);
    chk("hb_hdma5_b", {24'd0, v}, 32'h00);
    pulse();
    repeat (3) @(negedge clk);
    pulse();
    wait_idle("hb2");
    chk("hb2_count", 32'(wa.size()), 32'd32);
    if (wa.size() == 32) chk_block("hb2", 16, 16'hD010, 13'h0110);
    rd5(v);
    chk("hb_hdma5_c", {24'd0, v}, 32'hFF);

    // Terminate after one of four blocks
    wa.delete(); wd.delete();
    prog(16'hC200, 13'h0400);
    wreg(HDMA5, 8'h83);
    pulse();
    wait_idle("term");
    chk("term_count", 32'(wa.size()), 32'd16);
    rd5(v);
    chk("term_active", {24'd0, v}, 32'h02);
    wreg(HDMA5, 8'h00);
    rd5(v);
    chk("term_hdma5", {24'd0, v}, 32'h82);
    pulse();
    repeat (10) @(negedge clk);
    chk("term_no_more", 32'(wa.size()), 32'd16);
    chk("term_stall", {31'd0, stall}, 32'd0);

    // Destination wraps 1FFF -> 0000
    wa.delete(); wd.delete();
    prog(16'hC100, 13'h1FF0);
    wreg(HDMA5, 8'h01);
    wait_idle("wrap");
    chk("wrap_count", 32'(wa.size()), 32'd32);
    if (wa.size() == 32) begin
      chk("wrap_a15", {19'd0, wa[15]}, 32'h1FFF);
      chk("wrap_a16", {19'd0, wa[16]}, 32'h0000);
      chk("wrap_a31", {19'd0, wa[31]}, 32'h000F);
      chk("wrap_d31", {24'd0, wd[31]}, {24'd0, f(16'hC11F)});
    end

    // Reset at byte 5 of a GDMA
    wa.delete(); wd.delete();
    prog(16'hC000, 13'h0000);
    wreg(HDMA5, 8'h03);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
        @(negedge clk);
        if (wa.size() >= 5) hit = 1'b1;
      end
      chk("rstx_reach5", {31'd0, hit}, 32'd1);
    end
    #2 rst_ni = 1'b0;
    #1;
    chk("rstx_stall", {31'd0, stall}, 32'd0);
    chk("rstx_we", {31'd0, we}, 32'd0);
    chk("rstx_vaddr", {19'd0, vaddr}, 32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    begin
      int n0;
      n0 = wa.size();
      repeat (40) @(negedge clk);
      chk("rstx_no_writes", 32'(wa.size()), 32'(n0));
    end
    rd5(v);
    chk("rstx_hdma5", {24'd0, v}, 32'hFF);

    // LCD off: one H-blank block runs without a pulse
    wa.delete(); wd.delete();
    lcd = 1'b0;
    prog(16'hC300, 13'h0200);
    wreg(HDMA5, 8'h80);
    chk("lcdoff_stall", {31'd0, stall}, 32'd1);
    wait_idle("lcdoff");
    chk("lcdoff_count", 32'(wa.size()), 32'd16);
    if (wa.size() == 16) chk_block("lcdoff", 0, 16'hC300, 13'h0200);
    rd5(v);
    chk("lcdoff_hdma5", {24'd0, v}, 32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
